// File: rtl/cpu_pkg.sv
// Shared types for cpu_core: opcodes, sequencer states and flag bit positions.
// No logic; zero latency, no handshake.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_OR   = 4'd3,
      OP_AND  = 4'd4,
      OP_NOT  = 4'd5,
      OP_XOR  = 4'd6,
      OP_LSL  = 4'd7,
      OP_LSR  = 4'd8,
      OP_MOV  = 4'd9,
      OP_CMP  = 4'd10,
      OP_LDR  = 4'd11,
      OP_STR  = 4'd12,
      OP_JMP  = 4'd13,
      OP_HALT = 4'd14,
      OP_RSVD = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_EXEC   = 2'd1,
      ST_MEM    = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_G = 1;
   localparam int FLAG_L = 2;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for cpu_core: ADD..MOV results and unsigned CMP flags.
// Zero latency; no handshake or backpressure.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [3:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic [2:0]    flags_nxt,
   output logic          flags_we
);

   localparam logic [DW-1:0] DW_V = DW'(DW);

   always_comb begin
      result    = '0;
      flags_nxt = '0;
      flags_we  = 1'b0;
      case (opcode_e'(op))
         OP_ADD: result = a + b;
         OP_SUB: result = a - b;
         OP_OR:  result = a | b;
         OP_AND: result = a & b;
         OP_NOT: result = ~b;
         OP_XOR: result = a ^ b;
         OP_LSL: result = (b >= DW_V) ? '0 : (a << b);
         OP_LSR: result = (b >= DW_V) ? '0 : (a >> b);
         OP_MOV: result = b;
         OP_CMP: begin
            flags_we          = 1'b1;
            flags_nxt[FLAG_Z] = (a == b);
            flags_nxt[FLAG_G] = (a > b);
            flags_nxt[FLAG_L] = (a < b);
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 16-bit-instruction core: FETCH -> EXEC (-> MEM) with req/ack memory ports.
// 2 cycles per instruction, 3 for LDR/STR at zero wait; every ack wait cycle stalls one cycle.
module cpu_core
   import cpu_pkg::*;
#(
   parameter int DW       = 16,
   parameter int AW       = 8,
   parameter int RESET_PC = 0
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic [15:0]   imem_rdata,
   input  logic          imem_ack,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic [DW-1:0] dmem_rdata,
   input  logic          dmem_ack,
   output logic          halted,
   output logic [DW-1:0] r6_out
);

   localparam logic [DW-1:0] RESET_PC_V = DW'(RESET_PC);

   state_e        state_q, state_d;
   logic [DW-1:0] regs_q [8];
   logic [DW-1:0] regs_d [8];
   logic [15:0]   ir_q, ir_d;
   logic [2:0]    flags_q, flags_d;
   logic          imem_req_q, imem_req_d;
   logic          dmem_req_q, dmem_req_d;
   logic          dmem_we_q, dmem_we_d;
   logic [AW-1:0] dmem_addr_q, dmem_addr_d;
   logic [DW-1:0] dmem_wdata_q, dmem_wdata_d;

   opcode_e       op;
   logic [2:0]    rd;
   logic [2:0]    rs;
   logic [DW-1:0] opa;
   logic [DW-1:0] opb;
   logic [DW-1:0] pc_inc;
   logic [DW-1:0] alu_res;
   logic [2:0]    alu_flags;
   logic          alu_flags_we;
   logic          alu_wr;
   logic          jmp_taken;

   assign op        = opcode_e'(ir_q[15:12]);
   assign rd        = ir_q[11:9];
   assign rs        = ir_q[7:5];
   assign opa       = regs_q[rd];
   assign opb       = ir_q[8] ? DW'(ir_q[7:0]) : regs_q[rs];
   assign pc_inc    = regs_q[7] + DW'(1);
   assign alu_wr    = (op >= OP_ADD) && (op <= OP_MOV);
   // rd doubles as the condition mask for JMP; zero means unconditional
   assign jmp_taken = (rd == 3'd0) || ((rd & flags_q) != 3'd0);

   cpu_alu #(.DW(DW)) u_alu (
      .op        (ir_q[15:12]),
      .a         (opa),
      .b         (opb),
      .result    (alu_res),
      .flags_nxt (alu_flags),
      .flags_we  (alu_flags_we)
   );

   always_comb begin
      state_d      = state_q;
      regs_d       = regs_q;
      ir_d         = ir_q;
      flags_d      = flags_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_req_q && imem_ack) begin
               ir_d    = imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d   = ST_FETCH;
            regs_d[7] = pc_inc;
            // a write to r7 lands after the +1 above, so it replaces it
            if (alu_wr) regs_d[rd] = alu_res;
            if (alu_flags_we) flags_d = alu_flags;
            case (op)
               OP_JMP: if (jmp_taken) regs_d[7] = opb;
               OP_LDR, OP_STR: begin
                  regs_d[7]    = regs_q[7];
                  state_d      = ST_MEM;
                  dmem_we_d    = (op == OP_STR);
                  dmem_addr_d  = opb[AW-1:0];
                  dmem_wdata_d = opa;
               end
               OP_HALT: begin
                  regs_d[7] = regs_q[7];
                  state_d   = ST_HALTED;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            if (dmem_req_q && dmem_ack) begin
               state_d   = ST_FETCH;
               dmem_we_d = 1'b0;
               regs_d[7] = pc_inc;
               if (op == OP_LDR) regs_d[rd] = dmem_rdata;
            end
         end
         default: ;
      endcase
      imem_req_d = (state_d == ST_FETCH);
      dmem_req_d = (state_d == ST_MEM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         for (int i = 0; i < 7; i++) regs_q[i] <= '0;
         regs_q[7]    <= RESET_PC_V;
         ir_q         <= '0;
         flags_q      <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         regs_q       <= regs_d;
         ir_q         <= ir_d;
         flags_q      <= flags_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = regs_q[7][AW-1:0];
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign halted     = (state_q == ST_HALTED);
   assign r6_out     = regs_q[6];

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core (DW=32, AW=8, RESET_PC=4) with wait-stated memory models.
module tb_cpu_core;
   import cpu_pkg::*;

   typedef struct {
      logic [7:0] addr;
      int         gap;
   } fexp_t;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] dat;
      int          len;
   } dexp_t;

   logic        clk, rst;
   logic        imem_req, imem_ack;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [7:0]  dmem_addr;
   logic [31:0] dmem_wdata, dmem_rdata;
   logic        halted;
   logic [31:0] r6_out;

   logic [15:0] imem [256];
   logic [31:0] dmem [256];
   int          imem_wait, dmem_wait, icnt, dcnt;
   int          total, bad;
   fexp_t       fq[$];
   dexp_t       dq[$];

   int          cyc, last_f, dlen;
   logic        d_ok;
   logic [7:0]  d_a0;
   logic [31:0] d_w0;
   fexp_t       fe_m;
   dexp_t       de_m;

   cpu_core #(.DW(32), .AW(8), .RESET_PC(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .halted     (halted),
      .r6_out     (r6_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ei(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] k);
      return {op, rd, 1'b1, k};
   endfunction

   function automatic logic [15:0] er(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
      return {op, rd, 1'b0, rs, 5'b0};
   endfunction

   // place an instruction and expect it to be fetched in program order
   task automatic ins(input logic [7:0] a, input logic [15:0] w, input int gap);
      fexp_t fe;
      imem[a] = w;
      fe.addr = a;
      fe.gap  = gap;
      fq.push_back(fe);
   endtask

   task automatic dx(input logic we, input logic [7:0] a, input logic [31:0] d, input int len);
      dexp_t de;
      de.we   = we;
      de.addr = a;
      de.dat  = d;
      de.len  = len;
      dq.push_back(de);
   endtask

   task automatic wait_halt(input int lim);
      int n = 0;
      while (!halted && n < lim) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("halt_reached", halted, 1'b1);
   endtask

   // instruction memory responder
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
      icnt       = 0;
      forever begin
         @(posedge clk);
         #1;
         imem_ack = 1'b0;
         if (imem_req && !rst) begin
            if (icnt >= imem_wait) begin
               imem_ack   = 1'b1;
               imem_rdata = imem[imem_addr];
               icnt       = 0;
            end else icnt++;
         end else icnt = 0;
      end
   end

   // data memory responder
   initial begin
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      dcnt       = 0;
      forever begin
         @(posedge clk);
         #1;
         dmem_ack = 1'b0;
         if (dmem_req && !rst) begin
            if (dcnt >= dmem_wait) begin
               dmem_ack   = 1'b1;
               dmem_rdata = dmem[dmem_addr];
               if (dmem_we) dmem[dmem_addr] = dmem_wdata;
               dcnt       = 0;
            end else dcnt++;
         end else dcnt = 0;
      end
   end

   // monitor: pops expectations whenever a fetch or data access completes
   initial begin
      cyc = 0; last_f = 0; dlen = 0; d_ok = 1'b1; d_a0 = '0; d_w0 = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            cyc  = 0;
            dlen = 0;
         end else begin
            cyc++;
            if (dmem_req) begin
               if (dlen == 0) begin
                  d_a0 = dmem_addr;
                  d_w0 = dmem_wdata;
                  d_ok = 1'b1;
               end else if (dmem_addr !== d_a0 || dmem_wdata !== d_w0) d_ok = 1'b0;
               dlen++;
               if (dmem_ack) begin
                  chk("dmem_access_expected", dq.size() != 0, 1'b1);
                  if (dq.size() != 0) begin
                     de_m = dq.pop_front();
                     chk("dmem_we", dmem_we, de_m.we);
                     chk("dmem_addr", dmem_addr, de_m.addr);
                     if (de_m.we) chk("dmem_wdata", dmem_wdata, de_m.dat);
                     chk("dmem_req_len", dlen, de_m.len);
                     chk("dmem_stable", d_ok, 1'b1);
                  end
                  dlen = 0;
               end
            end
            if (imem_req && imem_ack) begin
               chk("fetch_expected", fq.size() != 0, 1'b1);
               if (fq.size() != 0) begin
                  fe_m = fq.pop_front();
                  chk("fetch_addr", imem_addr, fe_m.addr);
                  if (fe_m.gap >= 0) chk("fetch_gap", cyc - last_f, fe_m.gap);
               end
               last_f = cyc;
            end
         end
      end
   end

   initial begin
      int n;
      clk = 1'b0; rst = 1'b1;
      total = 0; bad = 0;
      imem_wait = 0; dmem_wait = 3;
      for (int i = 0; i < 256; i++) begin
         imem[i] = '0;
         dmem[i] = '0;
      end

      // program A: ALU chain at zero fetch wait, loads/stores with 3 wait cycles
      ins(8'h04, ei(OP_MOV, 1, 8'd5), -1);
      ins(8'h05, ei(OP_ADD, 1, 8'd3), 2);
      ins(8'h06, ei(OP_LSL, 1, 8'd2), 2);
      ins(8'h07, ei(OP_SUB, 1, 8'd1), 2);
      ins(8'h08, er(OP_MOV, 6, 1), 2);
      ins(8'h09, ei(OP_STR, 1, 8'h10), 2);
      ins(8'h0A, ei(OP_LDR, 2, 8'h10), 6);
      ins(8'h0B, ei(OP_STR, 2, 8'h11), 6);
      ins(8'h0C, ei(OP_HALT, 0, 8'h00), 6);
      dx(1'b1, 8'h10, 32'd31, 4);
      dx(1'b0, 8'h10, 32'd0, 4);
      dx(1'b1, 8'h11, 32'd31, 4);

      repeat (3) @(negedge clk);
      chk("rst_imem_addr", imem_addr, 8'h04);
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_dmem_req", dmem_req, 1'b0);
      chk("rst_dmem_we", dmem_we, 1'b0);
      chk("rst_dmem_addr", dmem_addr, 8'h00);
      chk("rst_dmem_wdata", dmem_wdata, 32'h0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_r6", r6_out, 32'h0);
      #2 rst = 1'b0;
      #1 chk("req_before_first_edge", imem_req, 1'b0);
      @(posedge clk);
      #1 chk("req_after_first_edge", imem_req, 1'b1);
      wait_halt(400);
      chk("progA_r6", r6_out, 32'd31);
      chk("progA_fetch_left", fq.size(), 0);
      chk("progA_dmem_left", dq.size(), 0);

      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req) n++;
      end
      chk("halt_no_fetch", n, 0);
      chk("halt_holds", halted, 1'b1);

      // program B: branches, PC writes, DW=32 wrap and shift limits, fetch wait 1
      imem_wait = 1; dmem_wait = 0;
      dmem[8'h30] = 32'h50;
      ins(8'h04, ei(OP_MOV, 1, 8'd31), -1);
      ins(8'h05, ei(OP_CMP, 1, 8'd31), 3);
      ins(8'h06, ei(OP_JMP, 1, 8'h20), 3);
      ins(8'h20, ei(OP_CMP, 1, 8'd40), 3);
      ins(8'h21, ei(OP_JMP, 1, 8'h30), 3);
      ins(8'h22, ei(OP_JMP, 4, 8'h28), 3);
      ins(8'h28, ei(OP_MOV, 7, 8'h40), 3);
      ins(8'h40, ei(OP_NOT, 3, 8'h00), 3);
      ins(8'h41, ei(OP_ADD, 3, 8'd1), 3);
      ins(8'h42, ei(OP_STR, 3, 8'h20), 3);
      ins(8'h43, ei(OP_NOT, 4, 8'h00), 4);
      ins(8'h44, ei(OP_LSR, 4, 8'd40), 3);
      ins(8'h45, ei(OP_NOT, 5, 8'h00), 3);
      ins(8'h46, ei(OP_LSR, 5, 8'd28), 3);
      ins(8'h47, ei(OP_STR, 4, 8'h21), 3);
      ins(8'h48, ei(OP_STR, 5, 8'h22), 4);
      ins(8'h49, ei(OP_MOV, 6, 8'hA5), 4);
      ins(8'h4A, ei(OP_JMP, 0, 8'h4D), 3);
      ins(8'h4D, ei(OP_LDR, 7, 8'h30), 3);
      ins(8'h50, ei(OP_HALT, 0, 8'h00), 4);
      dx(1'b1, 8'h20, 32'h0, 1);
      dx(1'b1, 8'h21, 32'h0, 1);
      dx(1'b1, 8'h22, 32'hF, 1);
      dx(1'b0, 8'h30, 32'h0, 1);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      wait_halt(600);
      chk("progB_r6", r6_out, 32'hA5);
      chk("progB_fetch_left", fq.size(), 0);
      chk("progB_dmem_left", dq.size(), 0);

      // reset while a slow fetch is outstanding
      imem_wait = 5;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("fetch_pending_req", imem_req, 1'b1);
      #1 rst = 1'b1;
      #1 chk("rst_async_drop_req", imem_req, 1'b0);
      chk("rst_mid_addr", imem_addr, 8'h04);
      chk("rst_mid_halted", halted, 1'b0);
      ins(8'h04, ei(OP_HALT, 0, 8'h00), -1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      wait_halt(100);
      chk("progC_fetch_left", fq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
